// File: rtl/hilo_sequencer.sv
// HI/LO sequencer for the E-stage multiply/divide path: accepts one op per start pulse,
// models mult/div latency with a down-counter and commits results to HI/LO on completion.
module hilo_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_start,
    input  logic [3:0]  i_mdu_op,
    input  logic [31:0] i_d1,
    input  logic [31:0] i_d2,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [3:0] OP_NOPE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_count;
    logic [3:0]  w_count_next;
    logic [3:0]  r_op;
    logic [3:0]  w_op_next;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] w_hi_next;
    logic [31:0] r_lo;
    logic [31:0] w_lo_next;
    logic        r_busy;

    logic        w_is_mdu;
    logic        w_is_mult;
    logic        w_accept;
    logic [3:0]  w_load;

    logic        w_mul_sa;
    logic        w_mul_sb;
    logic [63:0] w_prod;

    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_is_mdu  = (i_mdu_op >= OP_MULT) && (i_mdu_op <= OP_DIVU);
    assign w_is_mult = (i_mdu_op == OP_MULT) || (i_mdu_op == OP_MULTU);
    assign w_accept  = i_start && !i_req && !r_busy && w_is_mdu;
    assign w_load    = w_is_mult ? MULT_LOAD : DIV_LOAD;

    // Sign-extending to 64 bits makes one unsigned multiplier serve both mult and multu.
    assign w_mul_sa = r_a[31] && (r_op == OP_MULT);
    assign w_mul_sb = r_b[31] && (r_op == OP_MULT);
    assign w_prod   = {{32{w_mul_sa}}, r_a} * {{32{w_mul_sb}}, r_b};

    // Sign-magnitude division: truncation toward zero and the 0x80000000 / -1 case fall out
    // naturally, and the divisor is forced nonzero so a zero b never reaches the divider.
    assign w_div_signed = (r_op == OP_DIV);
    assign w_a_neg      = w_div_signed && r_a[31];
    assign w_b_neg      = w_div_signed && r_b[31];
    assign w_a_mag      = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_b_mag      = w_b_neg ? (32'd0 - r_b) : r_b;
    assign w_den        = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag      = w_a_mag / w_den;
    assign w_r_mag      = w_a_mag % w_den;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_op_next    = r_op;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StRun;
                    w_count_next = w_load;
                    w_op_next    = i_mdu_op;
                end else if (!i_req) begin
                    if (i_mdu_op == OP_MTHI) w_hi_next = i_d1;
                    if (i_mdu_op == OP_MTLO) w_lo_next = i_d1;
                end
            end
            StRun: begin
                w_count_next = r_count - 4'd1;
                if (r_count == 4'd1) begin
                    w_state_next = StIdle;
                    w_op_next    = OP_NOPE;
                    unique case (r_op)
                        OP_MULT, OP_MULTU: begin
                            w_hi_next = w_prod[63:32];
                            w_lo_next = w_prod[31:0];
                        end
                        OP_DIV, OP_DIVU: begin
                            if (r_b != 32'd0) begin
                                w_hi_next = w_rem;
                                w_lo_next = w_quot;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                w_state_next = StIdle;
                w_count_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_count <= 4'd0;
            r_op    <= OP_NOPE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_op    <= w_op_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_busy  <= (w_count_next != 4'd0);
            if (w_accept) begin
                r_a <= i_d1;
                r_b <= i_d2;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule
